imm_ext_arbiter: RTL and testbench
==================================

Name: imm_ext_arbiter

Overview:
- Shares the single immediate extender between two requesters: req0 is the decode stage, req1 the branch-target unit.
- Performs round-robin arbitration and latches the winner's 16-bit immediate and mode.
- Drives the extender's inputs for exactly one cycle, registers the 32-bit result, and returns it over a valid/ready response handshake.
- Zero-extend and upper-immediate modes are formed locally; the shared extender is used for sign-extension only.

Parameters:
- IMM_W, 16, immediate input width; the extender is fixed at 16.
- RES_W, 32, result width; fixed at 32.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- req0 / req1  in  1  request from requester 0 / 1; held until the matching rsp_valid is accepted.
- imm0 / imm1  in  16  immediate from requester 0 / 1; stable while its req is high.
- mode0 / mode1  in  2  extension mode of requester 0 / 1: 00 sign, 01 zero, 10 upper (imm<<16), 11 treated as sign.
- ext_inp  out  16  operand driven to the shared extender.
- ext_sel  out  1  extender enable; high only in state EXT.
- ext_res  in  32  combinational result from the extender.
- rsp_valid0 / rsp_valid1  out  1  result valid for requester 0 / 1; never both high.
- rsp_ready0 / rsp_ready1  in  1  acceptance by requester 0 / 1.
- rsp_data  out  32  registered result, shared by both requesters.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (rst_n low at an edge): state=IDLE, prio=0, rsp_valid0/1=0, rsp_data=0, ext_inp=0, ext_sel=0, busy=0.
- Reset mid-operation aborts the transaction with no response. Requesters must re-present their request.
- States: IDLE, EXT, RESP.
- IDLE, at least one req high at the edge:
  - Grant goes to the prio requester if its req is high, otherwise to the other one.
  - Latch gnt_id, imm and mode of the winner; prio <= ~gnt_id.
  - Mode 01 or 10: compute the result locally into rsp_data and go to RESP. ext_sel stays 0.
  - Mode 00 or 11: ext_inp <= latched imm, go to EXT.
- IDLE, no req: stay in IDLE. ext_inp holds its last value.
- EXT, exactly one cycle:
  - ext_sel=1 and ext_inp is stable.
  - At the closing edge: rsp_data <= ext_res, ext_sel <= 0, go to RESP.
- RESP:
  - rsp_valid[gnt_id]=1. rsp_data holds.
  - Leave when rsp_ready[gnt_id] is high at an edge: rsp_valid <= 0, return to IDLE.
  - Any number of stall cycles is legal. rsp_ready of the non-granted requester is ignored.
- Latency, req high to rsp_valid: 2 cycles for sign/11, 1 cycle for zero/upper. The minimum request-to-request turnaround is therefore 3 or 2 cycles.
- Local arithmetic:
  - zero = {16'b0, imm}
  - upper = {imm, 16'b0}
  - sign (via extender) = {{16{imm[15]}}, imm}
- Simultaneous requests: the prio requester wins. prio then flips, so with both requests held high the grants strictly alternate 0,1,0,1...
- No new grant is issued before RESP completes; there is no back-to-back overlap.
- A req dropped after grant does not abort the transaction: the response is still issued and held until ready.
- A req re-asserted in the same cycle a response is accepted is eligible in the next IDLE cycle.
- Payload is sampled only at the grant edge. Later changes to imm/mode do not affect the result in flight.
- busy = (state != IDLE).

Test Plan:
- Reset with all inputs high → every output 0, state IDLE. Release rst_n with req0=1, imm0=16'h8001, mode0=00 → ext_sel=1 on cycle 1, ext_inp=16'h8001. On cycle 2 rsp_valid0=1, rsp_data=32'hFFFF8001. rsp_ready0=1 → rsp_valid0=0 on the next cycle.
- req1=1, imm1=16'h8001, mode1=01 → ext_sel never rises. rsp_valid1=1 after 1 cycle with rsp_data=32'h00008001. Repeat with mode1=10 → rsp_data=32'h80010000.
- req0=req1=1 held continuously, rsp_ready0/1 tied to 1 → grant order 0,1,0,1. Each mode-00 transaction spans 3 cycles, and rsp_valid0/1 are never both high.
- RESP stall: rsp_ready0=0 for 5 cycles → rsp_valid0 and rsp_data stable and busy=1 throughout. Toggling imm0 during the stall does not change rsp_data. Driving rsp_ready1=1 has no effect.
- rst_n low during EXT → on the next cycle the state is IDLE, rsp_valid0/1=0, ext_sel=0, prio=0, and no response is emitted.
- mode0=11, imm0=16'h7FFF → rsp_data=32'h00007FFF via the extender path, with ext_sel asserted for exactly 1 cycle.

Source files
------------

// File: rtl/imm_ext_arbiter.sv
// Round-robin arbiter sharing one 16-bit sign extender between decode (req0) and branch-target (req1).
// Latency: 2 cycles req->rsp_valid for sign modes (00/11), 1 cycle for zero/upper modes (01/10).
// Backpressure: response held in RESP until the granted requester's rsp_ready; no new grant until then.
module imm_ext_arbiter #(
   parameter int IMM_W = 16,
   parameter int RES_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0,
   input  logic             req1,
   input  logic [IMM_W-1:0] imm0,
   input  logic [IMM_W-1:0] imm1,
   input  logic [1:0]       mode0,
   input  logic [1:0]       mode1,
   output logic [IMM_W-1:0] ext_inp,
   output logic             ext_sel,
   input  logic [RES_W-1:0] ext_res,
   output logic             rsp_valid0,
   output logic             rsp_valid1,
   input  logic             rsp_ready0,
   input  logic             rsp_ready1,
   output logic [RES_W-1:0] rsp_data,
   output logic             busy
);

   localparam logic [1:0] MODE_ZERO  = 2'b01;
   localparam logic [1:0] MODE_UPPER = 2'b10;
   localparam int         PAD_W      = RES_W - IMM_W;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXT  = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t             state_q,      state_d;
   logic               prio_q,       prio_d;
   logic               gnt_id_q,     gnt_id_d;
   logic [IMM_W-1:0]   ext_inp_q,    ext_inp_d;
   logic               ext_sel_q,    ext_sel_d;
   logic [RES_W-1:0]   rsp_data_q,   rsp_data_d;
   logic               rsp_valid0_q, rsp_valid0_d;
   logic               rsp_valid1_q, rsp_valid1_d;

   // Winner selection and its payload, only meaningful in IDLE.
   logic               win;
   logic [IMM_W-1:0]   win_imm;
   logic [1:0]         win_mode;
   logic               win_ready;

   // Pick the priority requester when it is asking, otherwise the other one.
   always_comb begin
      win = 1'b0;
      if (prio_q) begin
         win = req1 ? 1'b1 : 1'b0;
      end else begin
         win = req0 ? 1'b0 : 1'b1;
      end
      win_imm   = win ? imm1  : imm0;
      win_mode  = win ? mode1 : mode0;
      win_ready = gnt_id_q ? rsp_ready1 : rsp_ready0;
   end

   // Next-state and datapath updates; every register holds unless a state below moves it.
   always_comb begin
      state_d      = state_q;
      prio_d       = prio_q;
      gnt_id_d     = gnt_id_q;
      ext_inp_d    = ext_inp_q;
      ext_sel_d    = ext_sel_q;
      rsp_data_d   = rsp_data_q;
      rsp_valid0_d = rsp_valid0_q;
      rsp_valid1_d = rsp_valid1_q;

      case (state_q)
         S_IDLE: begin
            if (req0 || req1) begin
               gnt_id_d = win;
               prio_d   = ~win;
               if (win_mode == MODE_ZERO) begin
                  // Zero extension needs no extender: answer directly.
                  rsp_data_d   = {{PAD_W{1'b0}}, win_imm};
                  rsp_valid0_d = ~win;
                  rsp_valid1_d = win;
                  state_d      = S_RESP;
               end else if (win_mode == MODE_UPPER) begin
                  rsp_data_d   = {win_imm, {PAD_W{1'b0}}};
                  rsp_valid0_d = ~win;
                  rsp_valid1_d = win;
                  state_d      = S_RESP;
               end else begin
                  // Sign modes (00 and 11) borrow the shared extender for one cycle.
                  ext_inp_d = win_imm;
                  ext_sel_d = 1'b1;
                  state_d   = S_EXT;
               end
            end
         end

         S_EXT: begin
            rsp_data_d   = ext_res;
            ext_sel_d    = 1'b0;
            rsp_valid0_d = ~gnt_id_q;
            rsp_valid1_d = gnt_id_q;
            state_d      = S_RESP;
         end

         S_RESP: begin
            // Only the granted requester's ready can retire the response.
            if (win_ready) begin
               rsp_valid0_d = 1'b0;
               rsp_valid1_d = 1'b0;
               state_d      = S_IDLE;
            end
         end

         default: begin
            ext_sel_d    = 1'b0;
            rsp_valid0_d = 1'b0;
            rsp_valid1_d = 1'b0;
            state_d      = S_IDLE;
         end
      endcase
   end

   // State registers with synchronous active-low reset; reset aborts any transaction.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         prio_q       <= 1'b0;
         gnt_id_q     <= 1'b0;
         ext_inp_q    <= '0;
         ext_sel_q    <= 1'b0;
         rsp_data_q   <= '0;
         rsp_valid0_q <= 1'b0;
         rsp_valid1_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         prio_q       <= prio_d;
         gnt_id_q     <= gnt_id_d;
         ext_inp_q    <= ext_inp_d;
         ext_sel_q    <= ext_sel_d;
         rsp_data_q   <= rsp_data_d;
         rsp_valid0_q <= rsp_valid0_d;
         rsp_valid1_q <= rsp_valid1_d;
      end
   end

   assign ext_inp    = ext_inp_q;
   assign ext_sel    = ext_sel_q;
   assign rsp_data   = rsp_data_q;
   assign rsp_valid0 = rsp_valid0_q;
   assign rsp_valid1 = rsp_valid1_q;
   assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_imm_ext_arbiter.sv
// Directed bench for imm_ext_arbiter with a behavioural sign extender.
// Inputs change on the falling edge; outputs are sampled on the falling edge after each rising edge.
// Every expected value below is hand-derived from the block's cycle behaviour.
module tb_imm_ext_arbiter;

   logic        clk;
   logic        rst_n;
   logic        req0, req1;
   logic [15:0] imm0, imm1;
   logic [1:0]  mode0, mode1;
   logic [15:0] ext_inp;
   logic        ext_sel;
   logic [31:0] ext_res;
   logic        rsp_valid0, rsp_valid1;
   logic        rsp_ready0, rsp_ready1;
   logic [31:0] rsp_data;
   logic        busy;

   int n_pass  = 0;
   int n_total = 0;

   imm_ext_arbiter #(.IMM_W(16), .RES_W(32)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req0       (req0),
      .req1       (req1),
      .imm0       (imm0),
      .imm1       (imm1),
      .mode0      (mode0),
      .mode1      (mode1),
      .ext_inp    (ext_inp),
      .ext_sel    (ext_sel),
      .ext_res    (ext_res),
      .rsp_valid0 (rsp_valid0),
      .rsp_valid1 (rsp_valid1),
      .rsp_ready0 (rsp_ready0),
      .rsp_ready1 (rsp_ready1),
      .rsp_data   (rsp_data),
      .busy       (busy)
   );

   // Shared extender: sign-extends when enabled, garbage otherwise so misuse shows up.
   assign ext_res = ext_sel ? {{16{ext_inp[15]}}, ext_inp} : 32'hDEAD_BEEF;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   initial begin
      logic [15:0] tr_imm [2];
      logic        exp_id;
      logic [31:0] held;

      // Reset with every input high.
      rst_n = 1'b0;
      req0 = 1'b1; req1 = 1'b1;
      imm0 = 16'hFFFF; imm1 = 16'hFFFF;
      mode0 = 2'b11; mode1 = 2'b11;
      rsp_ready0 = 1'b1; rsp_ready1 = 1'b1;
      @(negedge clk);
      tick();
      tick();
      chk("rst_valid0", {31'b0, rsp_valid0}, 32'd0);
      chk("rst_valid1", {31'b0, rsp_valid1}, 32'd0);
      chk("rst_data",   rsp_data, 32'd0);
      chk("rst_ext_inp", {16'b0, ext_inp}, 32'd0);
      chk("rst_ext_sel", {31'b0, ext_sel}, 32'd0);
      chk("rst_busy",   {31'b0, busy}, 32'd0);

      // Sign extension through the extender for requester 0.
      rst_n = 1'b1; req1 = 1'b0;
      imm0 = 16'h8001; mode0 = 2'b00; rsp_ready0 = 1'b0; rsp_ready1 = 1'b0;
      tick();
      chk("s0_ext_sel", {31'b0, ext_sel}, 32'd1);
      chk("s0_ext_inp", {16'b0, ext_inp}, 32'h0000_8001);
      chk("s0_busy",    {31'b0, busy}, 32'd1);
      chk("s0_nov",     {31'b0, rsp_valid0}, 32'd0);
      tick();
      chk("s0_valid0",  {31'b0, rsp_valid0}, 32'd1);
      chk("s0_data",    rsp_data, 32'hFFFF_8001);
      chk("s0_sel_off", {31'b0, ext_sel}, 32'd0);
      rsp_ready0 = 1'b1; req0 = 1'b0;
      tick();
      chk("s0_done",    {31'b0, rsp_valid0}, 32'd0);
      chk("s0_idle",    {31'b0, busy}, 32'd0);

      // Zero and upper modes for requester 1 bypass the extender.
      req1 = 1'b1; imm1 = 16'h8001; mode1 = 2'b01;
      tick();
      chk("z1_valid1",  {31'b0, rsp_valid1}, 32'd1);
      chk("z1_sel",     {31'b0, ext_sel}, 32'd0);
      chk("z1_data",    rsp_data, 32'h0000_8001);
      rsp_ready1 = 1'b1; req1 = 1'b0;
      tick();
      chk("z1_done",    {31'b0, rsp_valid1}, 32'd0);
      req1 = 1'b1; mode1 = 2'b10; rsp_ready1 = 1'b0;
      tick();
      chk("u1_valid1",  {31'b0, rsp_valid1}, 32'd1);
      chk("u1_sel",     {31'b0, ext_sel}, 32'd0);
      chk("u1_data",    rsp_data, 32'h8001_0000);
      rsp_ready1 = 1'b1; req1 = 1'b0;
      tick();
      chk("u1_done",    {31'b0, rsp_valid1}, 32'd0);

      // Both requesting continuously with ready tied high: grants alternate 0,1,0,1.
      tr_imm[0] = 16'h1234; tr_imm[1] = 16'hF00F;
      imm0 = tr_imm[0]; imm1 = tr_imm[1];
      mode0 = 2'b00; mode1 = 2'b00;
      rsp_ready0 = 1'b1; rsp_ready1 = 1'b1;
      req0 = 1'b1; req1 = 1'b1;
      for (int t = 0; t < 4; t++) begin
         exp_id = t[0];
         tick();
         chk($sformatf("rr%0d_sel", t), {31'b0, ext_sel}, 32'd1);
         chk($sformatf("rr%0d_inp", t), {16'b0, ext_inp}, {16'b0, tr_imm[exp_id]});
         tick();
         chk($sformatf("rr%0d_v0", t), {31'b0, rsp_valid0}, {31'b0, ~exp_id});
         chk($sformatf("rr%0d_v1", t), {31'b0, rsp_valid1}, {31'b0, exp_id});
         chk($sformatf("rr%0d_data", t), rsp_data, {{16{tr_imm[exp_id][15]}}, tr_imm[exp_id]});
         if (t == 3) begin
            req0 = 1'b0; req1 = 1'b0;
         end
         tick();
         chk($sformatf("rr%0d_idle", t), {30'b0, rsp_valid1, rsp_valid0}, 32'd0);
         chk($sformatf("rr%0d_busy", t), {31'b0, busy}, 32'd0);
      end

      // Response stall: data holds, payload changes and the other ready are ignored.
      req0 = 1'b1; imm0 = 16'h00AA; mode0 = 2'b01; rsp_ready0 = 1'b0; rsp_ready1 = 1'b0;
      tick();
      chk("st_valid0", {31'b0, rsp_valid0}, 32'd1);
      chk("st_data",   rsp_data, 32'h0000_00AA);
      held = 32'h0000_00AA;
      rsp_ready1 = 1'b1;
      for (int c = 0; c < 5; c++) begin
         imm0 = imm0 ^ 16'hFF00;
         mode0 = 2'b10;
         tick();
         chk($sformatf("st%0d_v0", c),   {31'b0, rsp_valid0}, 32'd1);
         chk($sformatf("st%0d_v1", c),   {31'b0, rsp_valid1}, 32'd0);
         chk($sformatf("st%0d_data", c), rsp_data, held);
         chk($sformatf("st%0d_busy", c), {31'b0, busy}, 32'd1);
      end
      rsp_ready0 = 1'b1; rsp_ready1 = 1'b0; req0 = 1'b0;
      tick();
      chk("st_done", {31'b0, rsp_valid0}, 32'd0);

      // Reset during EXT aborts without a response and clears priority.
      req0 = 1'b1; imm0 = 16'h5555; mode0 = 2'b00; rsp_ready0 = 1'b0;
      tick();
      chk("ra_ext", {31'b0, ext_sel}, 32'd1);
      rst_n = 1'b0; req0 = 1'b0;
      tick();
      chk("ra_sel",   {31'b0, ext_sel}, 32'd0);
      chk("ra_valid", {30'b0, rsp_valid1, rsp_valid0}, 32'd0);
      chk("ra_busy",  {31'b0, busy}, 32'd0);
      rst_n = 1'b1;
      tick();
      chk("ra_quiet", {29'b0, busy, rsp_valid1, rsp_valid0}, 32'd0);
      // Priority was 1 before reset; after reset requester 0 must win a tie.
      req0 = 1'b1; req1 = 1'b1; imm0 = 16'h0001; imm1 = 16'h0002;
      mode0 = 2'b01; mode1 = 2'b01; rsp_ready0 = 1'b0; rsp_ready1 = 1'b0;
      tick();
      chk("ra_prio_v0", {31'b0, rsp_valid0}, 32'd1);
      chk("ra_prio_v1", {31'b0, rsp_valid1}, 32'd0);
      chk("ra_prio_d",  rsp_data, 32'h0000_0001);
      rsp_ready0 = 1'b1; req0 = 1'b0;
      tick();
      rsp_ready1 = 1'b1;
      tick();
      chk("ra_next_v1", {31'b0, rsp_valid1}, 32'd1);
      chk("ra_next_d",  rsp_data, 32'h0000_0002);
      req1 = 1'b0;
      tick();
      chk("ra_next_done", {31'b0, rsp_valid1}, 32'd0);

      // Mode 11 goes through the extender; req dropped after grant still completes.
      req0 = 1'b1; imm0 = 16'h7FFF; mode0 = 2'b11; rsp_ready0 = 1'b1;
      tick();
      chk("m3_sel",  {31'b0, ext_sel}, 32'd1);
      chk("m3_inp",  {16'b0, ext_inp}, 32'h0000_7FFF);
      req0 = 1'b0;
      tick();
      chk("m3_sel_off", {31'b0, ext_sel}, 32'd0);
      chk("m3_valid0",  {31'b0, rsp_valid0}, 32'd1);
      chk("m3_data",    rsp_data, 32'h0000_7FFF);
      tick();
      chk("m3_done",    {31'b0, rsp_valid0}, 32'd0);
      chk("m3_inp_hold", {16'b0, ext_inp}, 32'h0000_7FFF);
      tick();
      chk("m3_stay_idle", {29'b0, busy, ext_sel, rsp_valid0}, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
